// File: rtl/ps2_tx_pkg.sv
// Shared types and default timing constants for the PS/2 host-to-device transmitter.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SHIFT,
    S_ACK,
    S_WAIT_RELEASE,
    S_DONE
  } tx_state_e;

  localparam int DEFAULT_INHIBIT_COUNT = 5000;    // 100 us at 50 MHz
  localparam int DEFAULT_TIMEOUT_COUNT = 750000;  // 15 ms at 50 MHz
  localparam int TIMEOUT_W             = 20;

endpackage

// File: rtl/ps2_line_sync.sv
// Brings the raw PS/2 clock and data lines into the Clock_50 domain and flags
// falling edges of the synchronized PS/2 clock.
module ps2_line_sync (
  input  logic Clock_50,
  input  logic Reset,
  input  logic PS2_clock_i,
  input  logic PS2_data_i,
  output logic clock_sync,
  output logic data_sync,
  output logic clock_fall
);

  logic [1:0] clock_ff;
  logic [1:0] data_ff;
  logic       clock_prev;

  // Flops clear to 0, so an idle-high line right after reset cannot look like a fall.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      clock_ff   <= 2'b00;
      data_ff    <= 2'b00;
      clock_prev <= 1'b0;
    end else begin
      clock_ff   <= {clock_ff[0], PS2_clock_i};
      data_ff    <= {data_ff[0], PS2_data_i};
      clock_prev <= clock_ff[1];
    end
  end

  assign clock_sync = clock_ff[1];
  assign data_sync  = data_ff[1];
  assign clock_fall = clock_prev & ~clock_ff[1];

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device command transmitter: inhibits the clock, requests to send,
// shifts out data/parity/stop on device clock falls and checks the device ACK.
//
// state          | meaning
// S_IDLE         | lines released, waiting for PS2_tx_start
// S_INHIBIT      | clock held low for INHIBIT_COUNT cycles, start bit in last cycle
// S_REQUEST      | clock released, start bit driven, waiting for first device fall
// S_SHIFT        | each device fall drives the next data/parity/stop bit
// S_ACK          | next device fall samples the ACK bit
// S_WAIT_RELEASE | waiting for device to release clock and data
// S_DONE         | one-cycle done pulse, busy cleared
module ps2_transmitter
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_COUNT = DEFAULT_INHIBIT_COUNT,
  parameter int TIMEOUT_COUNT = DEFAULT_TIMEOUT_COUNT
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic       PS2_tx_start,
  input  logic [7:0] PS2_tx_data,
  input  logic       PS2_clock_i,
  input  logic       PS2_data_i,
  output logic       PS2_clock_oe,
  output logic       PS2_data_oe,
  output logic       PS2_tx_busy,
  output logic       PS2_tx_done,
  output logic       PS2_tx_error
);

  localparam int INH_W = (INHIBIT_COUNT > 1) ? $clog2(INHIBIT_COUNT) : 1;
  localparam logic [INH_W-1:0]     INH_LOAD = INH_W'(INHIBIT_COUNT - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LIMIT = TIMEOUT_W'(TIMEOUT_COUNT);

  tx_state_e            state;
  logic [7:0]           shift_reg;
  logic                 parity_bit;
  logic [3:0]           bit_count;
  logic [INH_W-1:0]     inh_cnt;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 clock_sync;
  logic                 data_sync;
  logic                 clock_fall;
  logic                 timed_out;

  ps2_line_sync u_line_sync (
    .Clock_50    (Clock_50),
    .Reset       (Reset),
    .PS2_clock_i (PS2_clock_i),
    .PS2_data_i  (PS2_data_i),
    .clock_sync  (clock_sync),
    .data_sync   (data_sync),
    .clock_fall  (clock_fall)
  );

  assign timed_out = (to_cnt == TO_LIMIT);

  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      state        <= S_IDLE;
      shift_reg    <= 8'h00;
      parity_bit   <= 1'b0;
      bit_count    <= 4'd0;
      inh_cnt      <= '0;
      to_cnt       <= '0;
      PS2_clock_oe <= 1'b0;
      PS2_data_oe  <= 1'b0;
      PS2_tx_busy  <= 1'b0;
      PS2_tx_done  <= 1'b0;
      PS2_tx_error <= 1'b0;
    end else begin
      PS2_tx_done <= 1'b0;
      // Later assignments on state changes override this and restart the count.
      to_cnt <= clock_fall ? '0 : to_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (PS2_tx_start) begin
            shift_reg    <= PS2_tx_data;
            parity_bit   <= ~^PS2_tx_data;
            PS2_tx_error <= 1'b0;
            PS2_tx_busy  <= 1'b1;
            PS2_clock_oe <= 1'b1;
            inh_cnt      <= INH_LOAD;
            to_cnt       <= '0;
            state        <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt <= INH_W'(1)) PS2_data_oe <= 1'b1;
          if (inh_cnt == '0) begin
            PS2_clock_oe <= 1'b0;
            to_cnt       <= '0;
            state        <= S_REQUEST;
          end else begin
            inh_cnt <= inh_cnt - 1'b1;
          end
        end

        // The fall leaving S_REQUEST is frame edge 1 and already drives data bit 0.
        S_REQUEST: begin
          if (timed_out) begin
            PS2_clock_oe <= 1'b0;
            PS2_data_oe  <= 1'b0;
            PS2_tx_error <= 1'b1;
            to_cnt       <= '0;
            state        <= S_DONE;
          end else if (clock_fall) begin
            PS2_data_oe <= ~shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[7:1]};
            bit_count   <= 4'd0;
            to_cnt      <= '0;
            state       <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (timed_out) begin
            PS2_clock_oe <= 1'b0;
            PS2_data_oe  <= 1'b0;
            PS2_tx_error <= 1'b1;
            to_cnt       <= '0;
            state        <= S_DONE;
          end else if (clock_fall) begin
            bit_count <= bit_count + 4'd1;
            if (bit_count < 4'd7) begin
              PS2_data_oe <= ~shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[7:1]};
            end else if (bit_count == 4'd7) begin
              PS2_data_oe <= ~parity_bit;
            end else begin
              PS2_data_oe <= 1'b0;
              to_cnt      <= '0;
              state       <= S_ACK;
            end
          end
        end

        S_ACK: begin
          if (timed_out) begin
            PS2_clock_oe <= 1'b0;
            PS2_data_oe  <= 1'b0;
            PS2_tx_error <= 1'b1;
            to_cnt       <= '0;
            state        <= S_DONE;
          end else if (clock_fall) begin
            if (data_sync) PS2_tx_error <= 1'b1;
            to_cnt <= '0;
            state  <= S_WAIT_RELEASE;
          end
        end

        S_WAIT_RELEASE: begin
          if (timed_out) begin
            PS2_clock_oe <= 1'b0;
            PS2_data_oe  <= 1'b0;
            PS2_tx_error <= 1'b1;
            to_cnt       <= '0;
            state        <= S_DONE;
          end else if (clock_sync && data_sync) begin
            to_cnt <= '0;
            state  <= S_DONE;
          end
        end

        S_DONE: begin
          PS2_tx_done <= 1'b1;
          PS2_tx_busy <= 1'b0;
          to_cnt      <= '0;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed and randomized checks of ps2_transmitter against a PS/2 device model
// and a frame model computed from the byte.
module tb_ps2_transmitter;

  localparam int INH = 50;
  localparam int TMO = 200;
  localparam int H   = 20;

  logic       Clock_50 = 1'b0;
  logic       Reset = 1'b1;
  logic       PS2_tx_start = 1'b0;
  logic [7:0] PS2_tx_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_line, data_line;
  logic       PS2_clock_oe, PS2_data_oe, PS2_tx_busy, PS2_tx_done, PS2_tx_error;

  int checks = 0;
  int errors = 0;
  int done_cycles = 0;

  assign clk_line  = dev_clk & ~PS2_clock_oe;
  assign data_line = dev_data & ~PS2_data_oe;

  ps2_transmitter #(.INHIBIT_COUNT(INH), .TIMEOUT_COUNT(TMO)) dut (
    .Clock_50     (Clock_50),
    .Reset        (Reset),
    .PS2_tx_start (PS2_tx_start),
    .PS2_tx_data  (PS2_tx_data),
    .PS2_clock_i  (clk_line),
    .PS2_data_i   (data_line),
    .PS2_clock_oe (PS2_clock_oe),
    .PS2_data_oe  (PS2_data_oe),
    .PS2_tx_busy  (PS2_tx_busy),
    .PS2_tx_done  (PS2_tx_done),
    .PS2_tx_error (PS2_tx_error)
  );

  always #10 Clock_50 = ~Clock_50;

  always @(posedge Clock_50) if (PS2_tx_done === 1'b1) done_cycles++;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line values as the device sees them: data LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = b[i];
    f[8] = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic pulse_start(input logic [7:0] b);
    @(negedge Clock_50);
    PS2_tx_start = 1'b1;
    PS2_tx_data  = b;
    @(negedge Clock_50);
    PS2_tx_start = 1'b0;
  endtask

  task automatic measure_inhibit();
    int t = 0;
    int n = 0;
    while (PS2_clock_oe !== 1'b1 && t < 10) begin
      @(negedge Clock_50);
      t++;
    end
    while (PS2_clock_oe === 1'b1 && n < 10 * INH) begin
      n++;
      @(negedge Clock_50);
    end
    check("inhibit_len", n, INH);
    check("start_bit_oe", PS2_data_oe, 1'b1);
  endtask

  task automatic dev_xfer(input int n_clk, input bit ack, output logic [9:0] got);
    int t = 0;
    got = '0;
    while (!(PS2_clock_oe === 1'b0 && data_line === 1'b0) && t < 2000) begin
      @(negedge Clock_50);
      t++;
    end
    check("request_seen", (t < 2000), 1);
    repeat (H) @(negedge Clock_50);
    for (int i = 1; i <= n_clk; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge Clock_50);
      dev_clk = 1'b1;
      if (i <= 10) got[i-1] = data_line;
      if (i == 10 && ack) dev_data = 1'b0;
      if (i == 11) dev_data = 1'b1;
      repeat (H) @(negedge Clock_50);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int t = 0;
    while (done_cycles == d0 && t < budget) begin
      @(negedge Clock_50);
      t++;
    end
    check("done_in_time", (done_cycles != d0), 1);
  endtask

  task automatic run_xfer(input logic [7:0] b, input int n_clk, input bit ack,
                          input bit exp_err, input bit retry, output logic [9:0] got);
    int d0 = done_cycles;
    pulse_start(b);
    check("busy_at_start", PS2_tx_busy, 1'b1);
    check("error_cleared", PS2_tx_error, 1'b0);
    measure_inhibit();
    if (retry) begin
      fork
        dev_xfer(n_clk, ack, got);
        begin
          repeat (150) @(negedge Clock_50);
          pulse_start(8'hFF);
        end
      join
    end else begin
      dev_xfer(n_clk, ack, got);
    end
    if (n_clk >= 10) check("frame", got, frame_of(b));
    if (n_clk < 11) check("busy_before_timeout", PS2_tx_busy, 1'b1);
    wait_done(d0, (n_clk < 11) ? TMO + 20 : 100);
    check("clock_oe_released", PS2_clock_oe, 1'b0);
    check("data_oe_released", PS2_data_oe, 1'b0);
    repeat (30) @(negedge Clock_50);
    check("done_once", done_cycles - d0, 1);
    check("busy_clear", PS2_tx_busy, 1'b0);
    check("error_flag", PS2_tx_error, exp_err);
  endtask

  initial begin
    logic [9:0] got;
    logic [7:0] rb;
    int d0;

    repeat (3) @(negedge Clock_50);
    check("rst_clock_oe", PS2_clock_oe, 1'b0);
    check("rst_data_oe", PS2_data_oe, 1'b0);
    check("rst_busy", PS2_tx_busy, 1'b0);
    check("rst_done", PS2_tx_done, 1'b0);
    check("rst_error", PS2_tx_error, 1'b0);
    Reset = 1'b0;
    repeat (5) @(negedge Clock_50);

    run_xfer(8'hED, 11, 1'b1, 1'b0, 1'b0, got);
    check("ed_bits", got, 10'b11_1110_1101);

    run_xfer(8'h07, 11, 1'b1, 1'b0, 1'b0, got);
    check("parity_07", got[8], 1'b0);
    run_xfer(8'h00, 11, 1'b1, 1'b0, 1'b0, got);
    check("parity_00", got[8], 1'b1);

    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom_range(0, 255));
      run_xfer(rb, 11, 1'b1, 1'b0, 1'b0, got);
    end

    run_xfer(8'hA5, 11, 1'b0, 1'b1, 1'b0, got);
    repeat (50) @(negedge Clock_50);
    check("error_held", PS2_tx_error, 1'b1);

    run_xfer(8'h5A, 4, 1'b1, 1'b1, 1'b0, got);

    run_xfer(8'hED, 11, 1'b1, 1'b0, 1'b1, got);

    d0 = done_cycles;
    pulse_start(8'h3C);
    measure_inhibit();
    dev_xfer(4, 1'b1, got);
    check("busy_mid_shift", PS2_tx_busy, 1'b1);
    @(negedge Clock_50);
    #3 Reset = 1'b1;
    #1;
    check("mid_rst_clock_oe", PS2_clock_oe, 1'b0);
    check("mid_rst_data_oe", PS2_data_oe, 1'b0);
    check("mid_rst_busy", PS2_tx_busy, 1'b0);
    check("mid_rst_done", PS2_tx_done, 1'b0);
    check("mid_rst_error", PS2_tx_error, 1'b0);
    repeat (5) @(negedge Clock_50);
    Reset = 1'b0;
    repeat (20) @(negedge Clock_50);
    check("no_done_on_reset", done_cycles - d0, 0);

    run_xfer(8'hF4, 11, 1'b1, 1'b0, 1'b0, got);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
